// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapped around a 1-cycle-latency dual-port RAM.
// Writes go straight to the RAM; reads are prefetched into a 2-entry skid buffer.
module ram_fifo_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_wr_add,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_rd_add,
    input  logic [DATA_W-1:0] ram_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic              inflight;
    logic [1:0]        skid_cnt;
    logic [1:0]        skid_after_pop;
    logic [DATA_W-1:0] skid0;
    logic [DATA_W-1:0] skid1;
    logic [2:0]        occ;
    logic              push;
    logic              pop;

    always_comb begin
        full           = (count == DEPTH_V);
        empty          = (count == '0);
        s_ready        = ~full;
        m_valid        = (skid_cnt != 2'd0);
        m_data         = skid0;
        push           = s_valid & s_ready;
        pop            = m_valid & m_ready;
        ram_wr         = push;
        ram_wr_add     = wr_ptr;
        ram_in         = s_data;
        skid_after_pop = skid_cnt - {1'b0, pop};
        // Slots the skid will need once everything already requested lands.
        occ            = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
        ram_rd         = (ram_cnt != '0) && (occ < 3'd2);
        ram_rd_add     = rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            skid_cnt <= '0;
            count    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (ram_rd)
                rd_ptr <= rd_ptr + 1'b1;
            inflight <= ram_rd;

            case ({push, ram_rd})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            skid_cnt <= skid_after_pop + {1'b0, inflight};
        end
    end

    // Head shifts on pop; capture lands in whichever slot is the tail after that shift.
    always_ff @(posedge clk) begin
        if (pop)
            skid0 <= skid1;
        if (inflight) begin
            if (skid_after_pop == 2'd0)
                skid0 <= ram_out;
            else
                skid1 <= ram_out;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 4096x64 registered-read RAM.
module tb_ram_fifo_ctrl;

    localparam int AW = 12;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          ram_wr;
    logic [AW-1:0] ram_wr_add;
    logic [DW-1:0] ram_in;
    logic          ram_rd;
    logic [AW-1:0] ram_rd_add;
    logic [DW-1:0] ram_out;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int checks   = 0;
    int failures = 0;

    ram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ram_wr(ram_wr), .ram_wr_add(ram_wr_add), .ram_in(ram_in),
        .ram_rd(ram_rd), .ram_rd_add(ram_rd_add), .ram_out(ram_out),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [4096];
    always @(posedge clk) begin
        if (ram_wr)
            mem[ram_wr_add] <= ram_in;
        ram_out <= ram_rd ? mem[ram_rd_add] : '0;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({s_ready, m_valid, empty, full} !== 4'b1010) begin
            failures++;
            $display("FAIL reset_flags got s_ready/m_valid/empty/full=%b exp=1010", {s_ready, m_valid, empty, full});
        end
        checks++;
        if (count !== 13'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", count);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] w;
        w = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        s_valid = 1'b1; s_data = w; m_ready = 1'b1;
        #1;
        checks++;
        if (ram_wr !== 1'b1 || ram_wr_add !== 12'd0 || ram_in !== w || ram_rd !== 1'b0) begin
            failures++;
            $display("FAIL single_write got wr=%b add=%0d in=%h rd=%b exp wr=1 add=0 in=%h rd=0", ram_wr, ram_wr_add, ram_in, ram_rd, w);
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        checks++;
        if (ram_rd !== 1'b1 || ram_rd_add !== 12'd0 || m_valid !== 1'b0 || count !== 13'd1) begin
            failures++;
            $display("FAIL single_issue got rd=%b add=%0d m_valid=%b count=%0d exp rd=1 add=0 m_valid=0 count=1", ram_rd, ram_rd_add, m_valid, count);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early_valid got=%b exp=0", m_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_data !== w) begin
            failures++;
            $display("FAIL single_read got valid=%b data=%h exp valid=1 data=%h", m_valid, m_data, w);
        end
        @(negedge clk);
        #1;
        checks++;
        if (count !== 13'd0 || empty !== 1'b1 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drained got count=%0d empty=%b m_valid=%b exp 0/1/0", count, empty, m_valid);
        end
    endtask

    // Fills to 4096, exercises pop-at-full, re-fills the freed slot, then drains.
    task automatic test_fill_full_drain();
        int nxt;
        apply_reset();
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 64'(i); m_ready = 1'b0;
            #1;
            checks++;
            if (ram_wr !== 1'b1 || ram_wr_add !== 12'(i)) begin
                failures++;
                $display("FAIL fill_write i=%0d got wr=%b add=%0d exp wr=1 add=%0d", i, ram_wr, ram_wr_add, i);
            end
        end
        @(negedge clk);
        s_valid = 1'b1; s_data = '1;
        #1;
        checks++;
        if (count !== 13'd4096 || full !== 1'b1 || s_ready !== 1'b0 || ram_wr !== 1'b0) begin
            failures++;
            $display("FAIL full_state got count=%0d full=%b s_ready=%b ram_wr=%b exp 4096/1/0/0", count, full, s_ready, ram_wr);
        end
        checks++;
        if (dut.skid_cnt !== 2'd2 || dut.ram_cnt !== 13'd4094) begin
            failures++;
            $display("FAIL full_internal got skid_cnt=%0d ram_cnt=%0d exp 2/4094", dut.skid_cnt, dut.ram_cnt);
        end
        @(negedge clk);
        s_valid = 1'b1; m_ready = 1'b1;
        #1;
        checks++;
        if (count !== 13'd4096 || s_ready !== 1'b0 || ram_wr !== 1'b0 || m_valid !== 1'b1 || m_data !== 64'd0) begin
            failures++;
            $display("FAIL full_pop got count=%0d s_ready=%b ram_wr=%b m_valid=%b m_data=%h exp 4096/0/0/1/0", count, s_ready, ram_wr, m_valid, m_data);
        end
        @(negedge clk);
        s_valid = 1'b1; s_data = 64'd4096; m_ready = 1'b0;
        #1;
        checks++;
        if (count !== 13'd4095 || s_ready !== 1'b1 || ram_wr !== 1'b1 || ram_wr_add !== 12'd0) begin
            failures++;
            $display("FAIL full_refill got count=%0d s_ready=%b ram_wr=%b add=%0d exp 4095/1/1/0", count, s_ready, ram_wr, ram_wr_add);
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        checks++;
        if (count !== 13'd4096) begin
            failures++;
            $display("FAIL full_recount got=%0d exp=4096", count);
        end
        nxt = 1;
        for (int c = 0; c < 6000 && nxt < 4097; c++) begin
            @(negedge clk);
            s_valid = 1'b0; m_ready = 1'b1;
            #1;
            if (m_valid) begin
                checks++;
                if (m_data !== 64'(nxt)) begin
                    failures++;
                    $display("FAIL drain_data got=%h exp=%h", m_data, 64'(nxt));
                end
                nxt++;
            end
        end
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        checks++;
        if (nxt !== 4097 || empty !== 1'b1 || count !== 13'd0) begin
            failures++;
            $display("FAIL drain_done got words=%0d empty=%b count=%0d exp 4096/1/0", nxt - 1, empty, count);
        end
    endtask

    task automatic test_back_to_back();
        int sent, recv, first;
        apply_reset();
        sent = 0; recv = 0; first = -1;
        for (int c = 0; c < 10200 && recv < 10000; c++) begin
            @(negedge clk);
            s_valid = (sent < 10000);
            s_data  = 64'hA000_0000_0000_0000 | 64'(sent);
            m_ready = 1'b1;
            #1;
            if (s_valid) begin
                checks++;
                if (s_ready !== 1'b1 || ram_wr_add !== 12'(sent)) begin
                    failures++;
                    $display("FAIL stream_write got s_ready=%b add=%0d exp 1/%0d", s_ready, ram_wr_add, sent % 4096);
                end
            end
            if (first >= 0 && recv < 10000) begin
                checks++;
                if (m_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_bubble cycle=%0d got m_valid=%b exp=1", c, m_valid);
                end
            end
            if (m_valid) begin
                if (first < 0) first = c;
                checks++;
                if (m_data !== (64'hA000_0000_0000_0000 | 64'(recv))) begin
                    failures++;
                    $display("FAIL stream_data got=%h exp=%h", m_data, 64'hA000_0000_0000_0000 | 64'(recv));
                end
                recv++;
            end
            if (s_valid && s_ready) sent++;
        end
        checks++;
        if (first !== 3 || recv !== 10000) begin
            failures++;
            $display("FAIL stream_summary got first=%0d recv=%0d exp 3/10000", first, recv);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] q[$];
        logic [DW-1:0] prev_data;
        logic          prev_stall;
        int sent, recv;
        apply_reset();
        sent = 0; recv = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 20000 && recv < 2000; c++) begin
            @(negedge clk);
            s_valid = (sent < 2000) && ($urandom_range(0, 3) != 0);
            s_data  = 64'h5555_0000_0000_0000 + 64'(sent);
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    failures++;
                    $display("FAIL bp_hold got valid=%b data=%h exp valid=1 data=%h", m_valid, m_data, prev_data);
                end
            end
            checks++;
            if (dut.skid_cnt > 2'd2) begin
                failures++;
                $display("FAIL bp_skid got=%0d exp<=2", dut.skid_cnt);
            end
            if (m_valid && m_ready) begin
                checks++;
                if (q.size() == 0 || m_data !== q[0]) begin
                    failures++;
                    $display("FAIL bp_data got=%h exp=%h", m_data, (q.size() == 0) ? 64'hx : q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                recv++;
            end
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                sent++;
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
        end
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0;
        #1;
        checks++;
        if (recv !== 2000 || empty !== 1'b1) begin
            failures++;
            $display("FAIL bp_summary got recv=%0d empty=%b exp 2000/1", recv, empty);
        end
    endtask

    task automatic test_reset_mid();
        int sent, recv;
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 64'hEEEE_0000_0000_0000 + 64'(i); m_ready = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        checks++;
        if (count !== 13'd100) begin
            failures++;
            $display("FAIL midrst_pre got count=%0d exp=100", count);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (count !== 13'd0 || m_valid !== 1'b0 || s_ready !== 1'b1 || empty !== 1'b1) begin
            failures++;
            $display("FAIL midrst_post got count=%0d m_valid=%b s_ready=%b empty=%b exp 0/0/1/1", count, m_valid, s_ready, empty);
        end
        sent = 0; recv = 0;
        for (int c = 0; c < 60 && recv < 5; c++) begin
            @(negedge clk);
            s_valid = (sent < 5);
            s_data  = 64'hC0DE_0000_0000_0000 + 64'(sent);
            m_ready = 1'b1;
            #1;
            if (s_valid) begin
                checks++;
                if (ram_wr_add !== 12'(sent)) begin
                    failures++;
                    $display("FAIL midrst_addr got=%0d exp=%0d", ram_wr_add, sent);
                end
            end
            if (m_valid) begin
                checks++;
                if (m_data !== 64'hC0DE_0000_0000_0000 + 64'(recv)) begin
                    failures++;
                    $display("FAIL midrst_data got=%h exp=%h", m_data, 64'hC0DE_0000_0000_0000 + 64'(recv));
                end
                recv++;
            end
            if (s_valid && s_ready) sent++;
        end
        checks++;
        if (recv !== 5) begin
            failures++;
            $display("FAIL midrst_count got=%0d exp=5", recv);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_full_drain();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
